// File: rtl/load_queue.sv
// Load queue: allocates loads at dispatch, searches the store queue for forwarding,
// issues misses to data memory one at a time, broadcasts on the CDB and retires in order.
module load_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rob_idxA,
    input  logic [4:0]  rob_idxB,
    input  logic        id_rd_mem_enA,
    input  logic        id_rd_mem_enB,
    input  logic        id_valid_IRA,
    input  logic        id_valid_IRB,
    input  logic [4:0]  SQ_tail,
    output logic [4:0]  LQ2RS_idxA,
    output logic [4:0]  LQ2RS_idxB,
    output logic        LQ2RS_idxA_write_en,
    output logic        LQ2RS_idxB_write_en,
    input  logic [4:0]  ALU_LQ_idxA,
    input  logic [4:0]  ALU_LQ_idxB,
    input  logic [63:0] ALU_load_addrA,
    input  logic [63:0] ALU_load_addrB,
    input  logic        ALU_rd_mem_enA,
    input  logic        ALU_rd_mem_enB,
    output logic [63:0] LQ2SQ_addr,
    output logic [4:0]  LQ2SQ_tail,
    output logic [4:0]  LQ2SQ_LQ_idx,
    output logic        LQ2SQ_search_en,
    input  logic [63:0] SQ2LQ_data,
    input  logic        SQ2LQ_write_en,
    input  logic [4:0]  SQ2LQ_LQ_idx,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic [4:0]  mem_tag,
    input  logic        mem_grant,
    input  logic        mem_resp_valid,
    input  logic [4:0]  mem_resp_tag,
    input  logic [63:0] mem_resp_data,
    output logic        LQ_cdb_valid,
    output logic [4:0]  LQ_cdb_rob_idx,
    output logic [63:0] LQ_cdb_data,
    input  logic        cdb_stall,
    input  logic        ROB2LQ_retire_en,
    input  logic        branch_recovery,
    output logic        LQ_full,
    output logic        LQ_almost_full
);

    typedef enum logic [2:0] {
        EMPTY, WAIT_ADDR, ADDR_RDY, MEM_WAIT, MEM_ISSUED, DONE, CDB_SENT
    } lq_state_e;

    lq_state_e   state_q   [DEPTH];
    lq_state_e   state_d   [DEPTH];
    logic [4:0]  rob_idx_q [DEPTH];
    logic [4:0]  rob_idx_d [DEPTH];
    logic [4:0]  sq_tail_q [DEPTH];
    logic [4:0]  sq_tail_d [DEPTH];
    logic [63:0] addr_q    [DEPTH];
    logic [63:0] addr_d    [DEPTH];
    logic [63:0] data_q    [DEPTH];
    logic [63:0] data_d    [DEPTH];
    logic [3:0]  head_q, head_d, tail_q, tail_d;
    logic [4:0]  count_q, count_d;
    logic        mem_busy_q, mem_busy_d;
    logic        req_lock_q, req_lock_d;
    logic [3:0]  req_idx_q, req_idx_d;
    logic        cdb_lock_q, cdb_lock_d;
    logic [3:0]  cdb_idx_q, cdb_idx_d;

    // Returns {found, index} of the entry in `target` closest to head.
    function automatic logic [4:0] find_oldest(input logic [3:0] head, input lq_state_e target,
                                               input lq_state_e st [DEPTH]);
        logic [4:0] r;
        logic [3:0] k;
        r = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            k = head + 4'(i);
            if (st[k] == target) r = {1'b1, k};
        end
        return r;
    endfunction

    logic [4:0] srch, mem_pick, cdb_pick;
    logic [3:0] mem_idx, cdb_idx;
    logic       load_a, load_b, alloc_a, alloc_b, retire_ok;
    logic [4:0] avail;

    assign srch     = find_oldest(head_q, ADDR_RDY, state_q);
    assign mem_pick = find_oldest(head_q, MEM_WAIT, state_q);
    assign cdb_pick = find_oldest(head_q, DONE, state_q);

    assign LQ2SQ_search_en = srch[4];
    assign LQ2SQ_addr      = srch[4] ? addr_q[srch[3:0]] : 64'd0;
    assign LQ2SQ_tail      = srch[4] ? sq_tail_q[srch[3:0]] : 5'd0;
    assign LQ2SQ_LQ_idx    = srch[4] ? {1'b0, srch[3:0]} : 5'd0;

    // A pending request or a stalled broadcast stays pinned to its entry until accepted.
    assign mem_idx  = req_lock_q ? req_idx_q : mem_pick[3:0];
    assign mem_req  = !mem_busy_q && (req_lock_q || mem_pick[4]);
    assign mem_addr = mem_req ? addr_q[mem_idx] : 64'd0;
    assign mem_tag  = mem_req ? {1'b0, mem_idx} : 5'd0;

    assign cdb_idx        = cdb_lock_q ? cdb_idx_q : cdb_pick[3:0];
    assign LQ_cdb_valid   = cdb_lock_q || cdb_pick[4];
    assign LQ_cdb_rob_idx = LQ_cdb_valid ? rob_idx_q[cdb_idx] : 5'd0;
    assign LQ_cdb_data    = LQ_cdb_valid ? data_q[cdb_idx] : 64'd0;

    assign LQ_full        = (count_q == 5'(DEPTH));
    assign LQ_almost_full = (count_q == 5'(DEPTH - 1));

    assign retire_ok = ROB2LQ_retire_en && (count_q != 5'd0) && (state_q[head_q] == CDB_SENT);
    assign avail     = count_q - 5'(retire_ok);
    assign load_a    = id_valid_IRA && id_rd_mem_enA;
    assign load_b    = id_valid_IRA && id_valid_IRB && id_rd_mem_enB;
    assign alloc_a   = load_a && (avail < 5'(DEPTH));
    assign alloc_b   = load_b && ((avail + 5'(alloc_a)) < 5'(DEPTH));

    assign LQ2RS_idxA_write_en = alloc_a;
    assign LQ2RS_idxB_write_en = alloc_b;
    assign LQ2RS_idxA          = alloc_a ? {1'b0, tail_q} : 5'd0;
    assign LQ2RS_idxB          = alloc_b ? {1'b0, tail_q + 4'(alloc_a)} : 5'd0;

    always_comb begin
        state_d    = state_q;
        rob_idx_d  = rob_idx_q;
        sq_tail_d  = sq_tail_q;
        addr_d     = addr_q;
        data_d     = data_q;
        head_d     = head_q;
        mem_busy_d = mem_busy_q;
        req_lock_d = mem_req && !mem_grant;
        req_idx_d  = mem_idx;
        cdb_lock_d = LQ_cdb_valid && cdb_stall;
        cdb_idx_d  = cdb_idx;

        if (retire_ok) begin
            state_d[head_q] = EMPTY;
            head_d          = head_q + 4'd1;
        end
        if (ALU_rd_mem_enA && !ALU_LQ_idxA[4] && state_q[ALU_LQ_idxA[3:0]] == WAIT_ADDR) begin
            addr_d[ALU_LQ_idxA[3:0]]  = ALU_load_addrA;
            state_d[ALU_LQ_idxA[3:0]] = ADDR_RDY;
        end
        if (ALU_rd_mem_enB && !ALU_LQ_idxB[4] && state_q[ALU_LQ_idxB[3:0]] == WAIT_ADDR) begin
            addr_d[ALU_LQ_idxB[3:0]]  = ALU_load_addrB;
            state_d[ALU_LQ_idxB[3:0]] = ADDR_RDY;
        end
        if (srch[4]) begin
            if (SQ2LQ_write_en && SQ2LQ_LQ_idx == LQ2SQ_LQ_idx) begin
                data_d[srch[3:0]]  = SQ2LQ_data;
                state_d[srch[3:0]] = DONE;
            end else begin
                state_d[srch[3:0]] = MEM_WAIT;
            end
        end
        // Any response frees the memory port, even one whose entry was flushed.
        if (mem_resp_valid) begin
            mem_busy_d = 1'b0;
            if (!mem_resp_tag[4] && state_q[mem_resp_tag[3:0]] == MEM_ISSUED) begin
                data_d[mem_resp_tag[3:0]]  = mem_resp_data;
                state_d[mem_resp_tag[3:0]] = DONE;
            end
        end
        if (mem_req && mem_grant) begin
            state_d[mem_idx] = MEM_ISSUED;
            mem_busy_d       = 1'b1;
        end
        if (LQ_cdb_valid && !cdb_stall) state_d[cdb_idx] = CDB_SENT;
        if (alloc_a) begin
            state_d[tail_q]   = WAIT_ADDR;
            rob_idx_d[tail_q] = rob_idxA;
            sq_tail_d[tail_q] = SQ_tail;
        end
        if (alloc_b) begin
            state_d[tail_q + 4'(alloc_a)]   = WAIT_ADDR;
            rob_idx_d[tail_q + 4'(alloc_a)] = rob_idxB;
            sq_tail_d[tail_q + 4'(alloc_a)] = SQ_tail;
        end
        tail_d  = tail_q + 4'(alloc_a) + 4'(alloc_b);
        count_d = count_q + 5'(alloc_a) + 5'(alloc_b) - 5'(retire_ok);
    end

    always_ff @(posedge clock) begin
        if (reset || branch_recovery) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i]   <= EMPTY;
                rob_idx_q[i] <= '0;
                sq_tail_q[i] <= '0;
                addr_q[i]    <= '0;
                data_q[i]    <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_busy_q <= 1'b0;
            req_lock_q <= 1'b0;
            req_idx_q  <= '0;
            cdb_lock_q <= 1'b0;
            cdb_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rob_idx_q  <= rob_idx_d;
            sq_tail_q  <= sq_tail_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_busy_q <= mem_busy_d;
            req_lock_q <= req_lock_d;
            req_idx_q  <= req_idx_d;
            cdb_lock_q <= cdb_lock_d;
            cdb_idx_q  <= cdb_idx_d;
        end
    end

endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: dispatch, forwarding hit, memory miss with delayed grant,
// full/wrap, CDB stall ordering and branch recovery.
module tb_load_queue;

    logic        clock, reset;
    logic [4:0]  rob_idxA, rob_idxB, SQ_tail;
    logic        id_rd_mem_enA, id_rd_mem_enB, id_valid_IRA, id_valid_IRB;
    logic [4:0]  LQ2RS_idxA, LQ2RS_idxB;
    logic        LQ2RS_idxA_write_en, LQ2RS_idxB_write_en;
    logic [4:0]  ALU_LQ_idxA, ALU_LQ_idxB;
    logic [63:0] ALU_load_addrA, ALU_load_addrB;
    logic        ALU_rd_mem_enA, ALU_rd_mem_enB;
    logic [63:0] LQ2SQ_addr;
    logic [4:0]  LQ2SQ_tail, LQ2SQ_LQ_idx;
    logic        LQ2SQ_search_en;
    logic [63:0] SQ2LQ_data;
    logic        SQ2LQ_write_en;
    logic [4:0]  SQ2LQ_LQ_idx;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [4:0]  mem_tag;
    logic        mem_grant, mem_resp_valid;
    logic [4:0]  mem_resp_tag;
    logic [63:0] mem_resp_data;
    logic        LQ_cdb_valid;
    logic [4:0]  LQ_cdb_rob_idx;
    logic [63:0] LQ_cdb_data;
    logic        cdb_stall, ROB2LQ_retire_en, branch_recovery;
    logic        LQ_full, LQ_almost_full;

    int tests_run = 0;
    int tests_failed = 0;

    load_queue dut (
        .clock(clock), .reset(reset),
        .rob_idxA(rob_idxA), .rob_idxB(rob_idxB),
        .id_rd_mem_enA(id_rd_mem_enA), .id_rd_mem_enB(id_rd_mem_enB),
        .id_valid_IRA(id_valid_IRA), .id_valid_IRB(id_valid_IRB),
        .SQ_tail(SQ_tail),
        .LQ2RS_idxA(LQ2RS_idxA), .LQ2RS_idxB(LQ2RS_idxB),
        .LQ2RS_idxA_write_en(LQ2RS_idxA_write_en), .LQ2RS_idxB_write_en(LQ2RS_idxB_write_en),
        .ALU_LQ_idxA(ALU_LQ_idxA), .ALU_LQ_idxB(ALU_LQ_idxB),
        .ALU_load_addrA(ALU_load_addrA), .ALU_load_addrB(ALU_load_addrB),
        .ALU_rd_mem_enA(ALU_rd_mem_enA), .ALU_rd_mem_enB(ALU_rd_mem_enB),
        .LQ2SQ_addr(LQ2SQ_addr), .LQ2SQ_tail(LQ2SQ_tail),
        .LQ2SQ_LQ_idx(LQ2SQ_LQ_idx), .LQ2SQ_search_en(LQ2SQ_search_en),
        .SQ2LQ_data(SQ2LQ_data), .SQ2LQ_write_en(SQ2LQ_write_en), .SQ2LQ_LQ_idx(SQ2LQ_LQ_idx),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_tag(mem_tag), .mem_grant(mem_grant),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .mem_resp_data(mem_resp_data),
        .LQ_cdb_valid(LQ_cdb_valid), .LQ_cdb_rob_idx(LQ_cdb_rob_idx), .LQ_cdb_data(LQ_cdb_data),
        .cdb_stall(cdb_stall), .ROB2LQ_retire_en(ROB2LQ_retire_en),
        .branch_recovery(branch_recovery),
        .LQ_full(LQ_full), .LQ_almost_full(LQ_almost_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then leave inputs free to change 1ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rob_idxA = '0; rob_idxB = '0; SQ_tail = '0;
        id_rd_mem_enA = 0; id_rd_mem_enB = 0; id_valid_IRA = 0; id_valid_IRB = 0;
        ALU_LQ_idxA = '0; ALU_LQ_idxB = '0; ALU_load_addrA = '0; ALU_load_addrB = '0;
        ALU_rd_mem_enA = 0; ALU_rd_mem_enB = 0;
        SQ2LQ_data = '0; SQ2LQ_write_en = 0; SQ2LQ_LQ_idx = '0;
        mem_grant = 0; mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
        cdb_stall = 0; ROB2LQ_retire_en = 0; branch_recovery = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic dispatch(input logic a_ld, input logic b_ld, input logic [4:0] ra,
                            input logic [4:0] rb, input logic [4:0] sqt);
        id_valid_IRA = 1; id_rd_mem_enA = a_ld; rob_idxA = ra;
        id_valid_IRB = b_ld; id_rd_mem_enB = b_ld; rob_idxB = rb;
        SQ_tail = sqt;
        settle();
    endtask

    task automatic alu_a(input logic [4:0] idx, input logic [63:0] addr);
        ALU_rd_mem_enA = 1; ALU_LQ_idxA = idx; ALU_load_addrA = addr;
    endtask

    task automatic sq_hit(input logic [4:0] idx, input logic [63:0] data);
        SQ2LQ_write_en = 1; SQ2LQ_LQ_idx = idx; SQ2LQ_data = data;
        settle();
    endtask

    initial begin
        reset = 0;
        do_reset();

        // Reset state
        settle();
        check_eq("rst_search_en", LQ2SQ_search_en, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_cdb_valid", LQ_cdb_valid, 0);
        check_eq("rst_full", LQ_full, 0);
        check_eq("rst_almost_full", LQ_almost_full, 0);
        check_eq("rst_cdb_rob", LQ_cdb_rob_idx, 0);

        // Dual dispatch, then forwarding hit on entry 0
        dispatch(1, 1, 5'd5, 5'd6, 5'd3);
        check_eq("disp_idxA", LQ2RS_idxA, 0);
        check_eq("disp_idxB", LQ2RS_idxB, 1);
        check_eq("disp_weA", LQ2RS_idxA_write_en, 1);
        check_eq("disp_weB", LQ2RS_idxB_write_en, 1);
        step(); idle();
        alu_a(5'd0, 64'h100);
        settle();
        check_eq("no_search_same_cycle", LQ2SQ_search_en, 0);
        step(); idle();
        settle();
        check_eq("hit_search_en", LQ2SQ_search_en, 1);
        check_eq("hit_search_addr", LQ2SQ_addr, 64'h100);
        check_eq("hit_search_idx", LQ2SQ_LQ_idx, 0);
        check_eq("hit_search_tail", LQ2SQ_tail, 3);
        sq_hit(5'd0, 64'hDEAD);
        step(); idle();
        settle();
        check_eq("hit_cdb_valid", LQ_cdb_valid, 1);
        check_eq("hit_cdb_rob", LQ_cdb_rob_idx, 5);
        check_eq("hit_cdb_data", LQ_cdb_data, 64'hDEAD);
        step();
        check_eq("hit_cdb_drained", LQ_cdb_valid, 0);

        // Miss on entry 1 with grant delayed three cycles
        ALU_rd_mem_enB = 1; ALU_LQ_idxB = 5'd1; ALU_load_addrB = 64'h200;
        step(); idle();
        settle();
        check_eq("miss_search_addr", LQ2SQ_addr, 64'h200);
        check_eq("miss_search_idx", LQ2SQ_LQ_idx, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("miss_req_held", mem_req, 1);
            check_eq("miss_addr_held", mem_addr, 64'h200);
            step();
        end
        mem_grant = 1;
        settle();
        check_eq("miss_req_grant", mem_req, 1);
        check_eq("miss_tag", mem_tag, 1);
        step(); idle();
        settle();
        check_eq("miss_req_after_grant", mem_req, 0);
        mem_resp_valid = 1; mem_resp_tag = 5'd1; mem_resp_data = 64'hBEEF;
        step(); idle();
        settle();
        check_eq("miss_cdb_valid", LQ_cdb_valid, 1);
        check_eq("miss_cdb_rob", LQ_cdb_rob_idx, 6);
        check_eq("miss_cdb_data", LQ_cdb_data, 64'hBEEF);
        step();
        ROB2LQ_retire_en = 1;
        step(); step();
        idle();
        dispatch(1, 0, 5'd7, 5'd0, 5'd0);
        check_eq("after_retire_idxA", LQ2RS_idxA, 2);
        check_eq("after_retire_idxB_we", LQ2RS_idxB_write_en, 0);
        step(); idle();

        // Fill to 16 with wrap, then retire+dispatch in the same cycle
        do_reset();
        dispatch(1, 0, 5'd0, 5'd0, 5'd0);
        step(); idle();
        alu_a(5'd0, 64'h40);
        step(); idle();
        sq_hit(5'd0, 64'h11);
        step(); idle();
        step();
        for (int k = 0; k < 7; k++) begin
            dispatch(1, 1, 5'(1 + 2 * k), 5'(2 + 2 * k), 5'd1);
            check_eq("fill_idxA", LQ2RS_idxA, 64'(1 + 2 * k));
            check_eq("fill_idxB", LQ2RS_idxB, 64'(2 + 2 * k));
            step(); idle();
        end
        settle();
        check_eq("fill15_almost", LQ_almost_full, 1);
        check_eq("fill15_full", LQ_full, 0);
        dispatch(1, 0, 5'd15, 5'd0, 5'd1);
        check_eq("fill16_idxA", LQ2RS_idxA, 15);
        step(); idle();
        settle();
        check_eq("fill16_full", LQ_full, 1);
        check_eq("fill16_almost", LQ_almost_full, 0);
        dispatch(1, 0, 5'd16, 5'd0, 5'd1);
        check_eq("full_drop_we", LQ2RS_idxA_write_en, 0);
        step(); idle();
        ROB2LQ_retire_en = 1;
        dispatch(1, 0, 5'd20, 5'd0, 5'd1);
        check_eq("wrap_we", LQ2RS_idxA_write_en, 1);
        check_eq("wrap_idxA", LQ2RS_idxA, 0);
        step(); idle();
        settle();
        check_eq("wrap_full_stays", LQ_full, 1);
        ROB2LQ_retire_en = 1;
        step(); idle();
        settle();
        check_eq("retire_ignored_full", LQ_full, 1);

        // CDB stall holds the older entry, then drains oldest-first
        do_reset();
        dispatch(1, 1, 5'd8, 5'd9, 5'd7);
        step(); idle();
        alu_a(5'd0, 64'h300);
        ALU_rd_mem_enB = 1; ALU_LQ_idxB = 5'd1; ALU_load_addrB = 64'h308;
        step(); idle();
        settle();
        check_eq("stall_search_first", LQ2SQ_LQ_idx, 0);
        sq_hit(5'd0, 64'hA0);
        step(); idle();
        settle();
        check_eq("stall_search_second", LQ2SQ_LQ_idx, 1);
        check_eq("stall_search_tail", LQ2SQ_tail, 7);
        cdb_stall = 1;
        sq_hit(5'd1, 64'hA1);
        check_eq("stall_c0_rob", LQ_cdb_rob_idx, 8);
        step(); idle();
        cdb_stall = 1;
        settle();
        check_eq("stall_c1_rob", LQ_cdb_rob_idx, 8);
        check_eq("stall_c1_data", LQ_cdb_data, 64'hA0);
        cdb_stall = 0;
        step();
        check_eq("drain_second_rob", LQ_cdb_rob_idx, 9);
        check_eq("drain_second_data", LQ_cdb_data, 64'hA1);
        step();
        check_eq("drain_done", LQ_cdb_valid, 0);

        // Branch recovery with a load in MEM_ISSUED
        do_reset();
        dispatch(1, 0, 5'd3, 5'd0, 5'd0);
        step(); idle();
        alu_a(5'd0, 64'h500);
        step(); idle();
        step();
        check_eq("rec_mem_req", mem_req, 1);
        check_eq("rec_mem_addr", mem_addr, 64'h500);
        mem_grant = 1;
        step(); idle();
        settle();
        check_eq("rec_issued_no_req", mem_req, 0);
        branch_recovery = 1;
        step(); idle();
        settle();
        check_eq("rec_search_en", LQ2SQ_search_en, 0);
        check_eq("rec_mem_req_clr", mem_req, 0);
        check_eq("rec_cdb_valid", LQ_cdb_valid, 0);
        mem_resp_valid = 1; mem_resp_tag = 5'd0; mem_resp_data = 64'h77;
        step(); idle();
        settle();
        check_eq("rec_late_resp_dropped", LQ_cdb_valid, 0);
        dispatch(1, 0, 5'd4, 5'd0, 5'd0);
        check_eq("rec_new_idx", LQ2RS_idxA, 0);
        step(); idle();
        alu_a(5'd0, 64'h600);
        step(); idle();
        step();
        check_eq("rec_new_req", mem_req, 1);
        check_eq("rec_new_addr", mem_addr, 64'h600);
        check_eq("rec_new_tag", mem_tag, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
